// File: rtl/tri_rasterizer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tri_rasterizer_if                                                        |
// | Triangle-in / pixel-out handshake bundle for the triangle rasterizer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface tri_rasterizer_if #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic          valid_in;
  logic          ready_out;
  logic [63:0]   tri_in;
  logic [11:0]   color_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [11:0]   pix_color;
  logic          tri_done;

  modport master (
    output valid_in, tri_in, color_in, pix_ready,
    input  ready_out, pix_valid, pix_x, pix_y, pix_color, tri_done
  );

  modport slave (
    input  valid_in, tri_in, color_in, pix_ready,
    output ready_out, pix_valid, pix_x, pix_y, pix_color, tri_done
  );
endinterface
`default_nettype wire

// File: rtl/tri_rasterizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tri_rasterizer                                                           |
// | Scans a triangle's clipped bounding box with incremental edge functions. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tri_rasterizer #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic             clk,
  input  logic             rst,
  tri_rasterizer_if.slave  bus
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic signed [25:0] X_MAX = 26'(H_RES - 1);
  localparam logic signed [25:0] Y_MAX = 26'(V_RES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EDGE  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic                ready_q, ready_d;
  logic signed [10:0]  vx_q [3], vx_d [3];
  logic signed [9:0]   vy_q [3], vy_d [3];
  logic [11:0]         color_q, color_d;
  logic [XW-1:0]       xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
  logic [YW-1:0]       ymin_q, ymin_d, ymax_q, ymax_d, y_q, y_d;
  logic signed [25:0]  e_row_q [3], e_row_d [3];
  logic signed [25:0]  e_cur_q [3], e_cur_d [3];
  logic                pix_valid_q, pix_valid_d;
  logic [XW-1:0]       pix_x_q, pix_x_d;
  logic [YW-1:0]       pix_y_q, pix_y_d;
  logic [11:0]         pix_color_q, pix_color_d;
  logic                tri_done_q, tri_done_d;

  logic signed [25:0]  wx [3], wy [3], ea [3], eb [3], e0 [3];
  logic signed [25:0]  area, lo_x, hi_x, lo_y, hi_y, px0, py0;
  logic                off_screen, covered, stall;

  // Vertex geometry, bounding box and edge setup, all at 26-bit signed.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wx[i] = {{15{vx_q[i][10]}}, vx_q[i]};
      wy[i] = {{16{vy_q[i][9]}}, vy_q[i]};
    end
    area = (wx[1] - wx[0]) * (wy[2] - wy[0]) - (wy[1] - wy[0]) * (wx[2] - wx[0]);
    lo_x = wx[0]; hi_x = wx[0]; lo_y = wy[0]; hi_y = wy[0];
    for (int i = 1; i < 3; i++) begin
      if (wx[i] < lo_x) lo_x = wx[i];
      if (wx[i] > hi_x) hi_x = wx[i];
      if (wy[i] < lo_y) lo_y = wy[i];
      if (wy[i] > hi_y) hi_y = wy[i];
    end
    if (lo_x < 0) lo_x = '0;
    if (lo_y < 0) lo_y = '0;
    if (hi_x > X_MAX) hi_x = X_MAX;
    if (hi_y > Y_MAX) hi_y = Y_MAX;
    off_screen = (lo_x > hi_x) || (lo_y > hi_y);
    px0 = {{(26-XW){1'b0}}, xmin_q};
    py0 = {{(26-YW){1'b0}}, ymin_q};
    for (int i = 0; i < 3; i++) begin
      ea[i] = wy[i] - wy[(i+1)%3];
      eb[i] = wx[(i+1)%3] - wx[i];
      e0[i] = eb[i] * (py0 - wy[i]) + ea[i] * (px0 - wx[i]);
    end
    covered = !e_cur_q[0][25] && !e_cur_q[1][25] && !e_cur_q[2][25];
    stall   = pix_valid_q && !bus.pix_ready;
  end

  always_comb begin
    state_d     = state_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    color_d     = color_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    x_d         = x_q;
    y_d         = y_q;
    e_row_d     = e_row_q;
    e_cur_d     = e_cur_q;
    pix_valid_d = stall ? pix_valid_q : 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    tri_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.valid_in && ready_q) begin
          vx_d[0] = bus.tri_in[63:53]; vy_d[0] = bus.tri_in[52:43];
          vx_d[1] = bus.tri_in[42:32]; vy_d[1] = bus.tri_in[31:22];
          vx_d[2] = bus.tri_in[21:11]; vy_d[2] = bus.tri_in[10:1];
          color_d = bus.color_in;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (area == 0 || off_screen) begin
          state_d = S_DONE;
        end else begin
          // Normalize winding so that interior points give non-negative edges.
          if (area < 0) begin
            vx_d[1] = vx_q[2]; vy_d[1] = vy_q[2];
            vx_d[2] = vx_q[1]; vy_d[2] = vy_q[1];
          end
          xmin_d  = lo_x[XW-1:0];
          xmax_d  = hi_x[XW-1:0];
          ymin_d  = lo_y[YW-1:0];
          ymax_d  = hi_y[YW-1:0];
          state_d = S_EDGE;
        end
      end
      S_EDGE: begin
        e_row_d = e0;
        e_cur_d = e0;
        x_d     = xmin_q;
        y_d     = ymin_q;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!stall) begin
          pix_valid_d = covered;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          pix_color_d = color_q;
          if (x_q < xmax_q) begin
            x_d = x_q + XW'(1);
            for (int i = 0; i < 3; i++) e_cur_d[i] = e_cur_q[i] + ea[i];
          end else begin
            x_d = xmin_q;
            y_d = y_q + YW'(1);
            for (int i = 0; i < 3; i++) begin
              e_row_d[i] = e_row_q[i] + eb[i];
              e_cur_d[i] = e_row_q[i] + eb[i];
            end
            if (y_q == ymax_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!stall) begin
          tri_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      color_q     <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      tri_done_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i]    <= '0;
        vy_q[i]    <= '0;
        e_row_q[i] <= '0;
        e_cur_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      color_q     <= color_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      tri_done_q  <= tri_done_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      e_row_q     <= e_row_d;
      e_cur_q     <= e_cur_d;
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_color = pix_color_q;
  assign bus.tri_done  = tri_done_q;
endmodule
`default_nettype wire
